// File: rtl/rcpu_io_pkg.sv
// Shared RCPU IO constants: one-hot select bits, SPI command/status field positions
// and the SPI bit engine state type.
package rcpu_io_pkg;

  localparam int IO_PMOD    = 0;
  localparam int IO_UART    = 12;
  localparam int IO_MISC_IN = 13;
  localparam int IO_SPI     = 14;

  // Field positions use the bus numbering, where bit 15 is the LSB.
  localparam int SPI_CMD_CS   = 6;
  localparam int SPI_CS_VAL   = 7;
  localparam int SPI_BUSY_BIT = 7;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_LOW,
    SPI_HIGH
  } spi_state_e;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode 0 byte engine, MSB first: SCK phase sequencing, phase divider,
// bit counter and the tx/rx shift registers.
//
// state    | meaning
// SPI_IDLE | sck=0, not busy, waiting for start_i
// SPI_LOW  | sck=0 for CLKDIV cycles, mosi holds the current bit
// SPI_HIGH | sck=1 for CLKDIV cycles, miso already captured on entry
module spi_bit_engine
  import rcpu_io_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic [7:0] byte_o,
  output logic       sck_o,
  output logic       mosi_o
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLKDIV - 1);

  spi_state_e state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= SPI_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_byte_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_byte_q <= rx_byte_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_byte_d = rx_byte_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    case (state_q)
      SPI_IDLE: begin
        sck_d = 1'b0;
        if (start_i) begin
          tx_d    = byte_i;
          mosi_d  = byte_i[7];
          cnt_d   = '0;
          div_d   = DIV_RELOAD;
          state_d = SPI_LOW;
        end
      end
      SPI_LOW: begin
        if (div_q == 8'd0) begin
          sck_d   = 1'b1;
          rx_d    = {rx_q[6:0], miso_i};
          div_d   = DIV_RELOAD;
          state_d = SPI_HIGH;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      SPI_HIGH: begin
        if (div_q == 8'd0) begin
          sck_d = 1'b0;
          if (cnt_q == 3'd7) begin
            // rx_q already holds the eighth bit, captured when this phase began.
            rx_byte_d = rx_q;
            state_d   = SPI_IDLE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            div_d   = DIV_RELOAD;
            state_d = SPI_LOW;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      default: state_d = SPI_IDLE;
    endcase
  end

  assign busy_o = (state_q != SPI_IDLE);
  assign byte_o = rx_byte_q;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/io_spi_master.sv
// Memory-mapped SPI master on the RCPU IO bus: one-hot decode, software chip select,
// registered status/rx read word (zero when unselected so it can be OR-ed into the read mux).
module io_spi_master
  import rcpu_io_pkg::*;
#(
  parameter int SEL_BIT = IO_SPI,
  parameter int CLKDIV  = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [0:15] io_address,
  input  logic [0:15] io_write_data,
  output logic [0:15] io_read_data,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  logic        sel;
  logic        wr_accept;
  logic        start;
  logic        busy;
  logic [7:0]  rx_byte;
  logic [0:15] status_word;
  logic        cs_n_q, cs_n_d;
  logic [0:15] rd_q, rd_d;
  logic        unused_bus;

  assign sel       = io_address[SEL_BIT];
  // Every write, CS commands included, is dropped while a byte is in flight.
  assign wr_accept = io_write_enable & sel & ~busy;
  assign start     = wr_accept & ~io_write_data[SPI_CMD_CS];

  always_comb begin
    status_word               = '0;
    status_word[SPI_BUSY_BIT] = busy;
    status_word[8:15]         = rx_byte;
  end

  always_comb begin
    cs_n_d = cs_n_q;
    rd_d   = rd_q;
    if (wr_accept && io_write_data[SPI_CMD_CS]) begin
      cs_n_d = ~io_write_data[SPI_CS_VAL];
    end
    if (io_read_enable) begin
      rd_d = sel ? status_word : '0;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cs_n_q <= 1'b1;
      rd_q   <= '0;
    end else begin
      cs_n_q <= cs_n_d;
      rd_q   <= rd_d;
    end
  end

  spi_bit_engine #(
    .CLKDIV(CLKDIV)
  ) u_engine (
    .clk    (clk),
    .resetq (resetq),
    .start_i(start),
    .byte_i (io_write_data[8:15]),
    .miso_i (miso),
    .busy_o (busy),
    .byte_o (rx_byte),
    .sck_o  (sck),
    .mosi_o (mosi)
  );

  assign io_read_data = rd_q;
  assign cs_n         = cs_n_q;
  assign unused_bus   = ^{io_address, io_write_data[0:5]};

endmodule

// File: tb/tb_io_spi_master.sv
// Bench for io_spi_master: two instances (CLKDIV=2 with registered loopback, CLKDIV=1 with a
// fixed-byte slave) share one IO bus; a cycle-level transaction model feeds read and MOSI scoreboards.
module tb_io_spi_master;

  localparam int          C0    = 2;
  localparam int          C1    = 1;
  localparam logic [15:0] A_SPI = 16'h0002;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [0:15] io_address = '0;
  logic [0:15] io_write_data = '0;
  logic [0:15] rd0, rd1;
  logic        sck0, sck1, mosi0, mosi1, cs_n0, cs_n1;
  logic        miso0 = 1'b0, miso1 = 1'b0;

  always #5 clk = ~clk;

  io_spi_master #(.SEL_BIT(14), .CLKDIV(C0)) u_dut0 (
    .clk(clk), .resetq(resetq), .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_address(io_address), .io_write_data(io_write_data), .io_read_data(rd0),
    .sck(sck0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0));

  io_spi_master #(.SEL_BIT(14), .CLKDIV(C1)) u_dut1 (
    .clk(clk), .resetq(resetq), .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_address(io_address), .io_write_data(io_write_data), .io_read_data(rd1),
    .sck(sck1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1));

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          cdiv[2] = '{C0, C1};
  int          busy_end[2];
  logic [7:0]  rx_cur[2], rx_next[2];
  logic        cs_m[2];
  logic [15:0] rq[2][$];
  logic        cq[2][$];
  logic [7:0]  mq[2][$];
  logic [7:0]  slave_pat = 8'h5A;

  always @(posedge clk) cyc++;

  // Pad register between mosi and miso on the CLKDIV=2 instance.
  always @(posedge clk) miso0 <= mosi0;

  // Slave returns slave_pat MSB first, advancing one bit after each SCK rise it observes.
  int   rcnt = 0;
  logic s1_last = 1'b0;
  always @(posedge clk) begin
    if (!resetq) begin
      rcnt    = 0;
      s1_last = 1'b0;
      miso1  <= slave_pat[7];
    end else begin
      if (sck1 && !s1_last) rcnt++;
      s1_last = sck1;
      miso1  <= slave_pat[7 - (rcnt % 8)];
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_end[d] = 0;
      rx_cur[d]   = 8'h00;
      rx_next[d]  = 8'h00;
      cs_m[d]     = 1'b1;
      mq[d].delete();
    end
  endtask

  // Issue one bus cycle at the next posedge; the model is evaluated for that edge index.
  task automatic bus_op(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
    int j = cyc + 1;
    bit sel = addr[1];
    for (int d = 0; d < 2; d++) begin
      bit bz;
      if (j >= busy_end[d]) rx_cur[d] = rx_next[d];
      bz = (j < busy_end[d]);
      if (rd) rq[d].push_back(sel ? {7'd0, bz, rx_cur[d]} : 16'h0000);
      if (wr && sel && !bz) begin
        if (wdata[9]) begin
          cs_m[d] = ~wdata[8];
        end else begin
          busy_end[d] = j + 16 * cdiv[d] + 1;
          rx_next[d]  = (d == 0) ? wdata[7:0] : slave_pat;
          mq[d].push_back(wdata[7:0]);
        end
      end
      if (rd) cq[d].push_back(cs_m[d]);
    end
    io_read_enable  = rd;
    io_write_enable = wr;
    io_address      = addr;
    io_write_data   = wdata;
    @(negedge clk);
    io_read_enable  = 1'b0;
    io_write_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sck0", 16'(sck0), 16'h0);
    chk("rst_sck1", 16'(sck1), 16'h0);
    chk("rst_cs_n0", 16'(cs_n0), 16'h1);
    chk("rst_cs_n1", 16'(cs_n1), 16'h1);
    chk("rst_rd0", rd0, 16'h0000);
    chk("rst_rd1", rd1, 16'h0000);
  endtask

  // Read monitor: a strobe seen at an edge means the DUT presents data just after it.
  initial begin
    logic        rd_edge;
    logic [15:0] got;
    logic        gcs;
    forever begin
      @(posedge clk);
      rd_edge = io_read_enable;
      #1;
      if (rd_edge) begin
        for (int d = 0; d < 2; d++) begin
          got = (d == 0) ? rd0 : rd1;
          gcs = (d == 0) ? cs_n0 : cs_n1;
          if (rq[d].size() == 0 || cq[d].size() == 0) begin
            chk("read_unexpected", got, 16'hxxxx);
          end else begin
            chk((d == 0) ? "read_data0" : "read_data1", got, rq[d].pop_front());
            chk((d == 0) ? "cs_n0" : "cs_n1", 16'(gcs), 16'(cq[d].pop_front()));
          end
        end
      end
    end
  end

  // SPI monitor: collects MOSI at each SCK rise, checks rise spacing and MOSI stability while high.
  logic [7:0] bits[2];
  int         nb[2] = '{0, 0};
  int         last_rise[2];
  logic       sl[2] = '{1'b0, 1'b0};
  logic       ml[2] = '{1'b0, 1'b0};
  initial begin
    logic s, m;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        s = (d == 0) ? sck0 : sck1;
        m = (d == 0) ? mosi0 : mosi1;
        if (!resetq) begin
          nb[d] = 0;
          sl[d] = 1'b0;
        end else begin
          if (s && sl[d]) chk("mosi_hold", 16'(m), 16'(ml[d]));
          if (s && !sl[d]) begin
            if (nb[d] > 0) chk("sck_period", 16'(cyc - last_rise[d]), 16'(2 * cdiv[d]));
            last_rise[d] = cyc;
            bits[d] = {bits[d][6:0], m};
            nb[d]++;
            if (nb[d] == 8) begin
              if (mq[d].size() == 0) chk("spi_extra_byte", 16'(bits[d]), 16'hxxxx);
              else chk((d == 0) ? "mosi_byte0" : "mosi_byte1", 16'(bits[d]), 16'(mq[d].pop_front()));
              nb[d] = 0;
            end
          end
          sl[d] = s;
          ml[d] = m;
        end
      end
    end
  end

  initial begin
    int          kind;
    logic [15:0] addr, data;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #3 resetq = 1'b1;
    @(negedge clk);

    bus_op(1, 0, A_SPI, 16'h0000);
    bus_op(0, 1, A_SPI, 16'h0300);
    bus_op(0, 1, A_SPI, 16'h00A5);
    repeat (36) bus_op(1, 0, A_SPI, 16'h0000);

    // Writes during a transfer, including a CS-off command, must be dropped.
    bus_op(0, 1, A_SPI, 16'h003C);
    idle(3);
    bus_op(1, 0, A_SPI, 16'h0000);
    bus_op(0, 1, A_SPI, 16'h00FF);
    bus_op(0, 1, A_SPI, 16'h0200);
    idle(36);
    bus_op(1, 0, A_SPI, 16'h0000);

    bus_op(1, 0, 16'h0001, 16'h0000);
    bus_op(0, 1, 16'h8000, 16'h0011);
    bus_op(0, 1, 16'h0001, 16'h0200);
    idle(40);
    bus_op(1, 0, A_SPI, 16'h0000);

    bus_op(0, 1, A_SPI, 16'h0011);
    idle(36);
    bus_op(1, 1, A_SPI, 16'h0011);
    bus_op(1, 0, A_SPI, 16'h0000);
    idle(36);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      addr = ($urandom_range(0, 7) == 0) ? (16'h0001 << $urandom_range(2, 15)) : A_SPI;
      if (kind < 2) data = 16'h0200 | (16'($urandom_range(0, 1)) << 8);
      else          data = 16'($urandom_range(0, 255));
      if (kind < 6)       bus_op(0, 1, addr, data);
      else if (kind < 9)  bus_op(1, 0, addr, data);
      else                bus_op(1, 1, addr, data);
      idle($urandom_range(0, 12));
    end
    idle(40);

    // Reset in the middle of a transfer with CS asserted.
    bus_op(0, 1, A_SPI, 16'h0300);
    bus_op(0, 1, A_SPI, 16'h00C3);
    idle(5);
    @(posedge clk);
    #3 resetq = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #3 resetq = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    bus_op(1, 0, A_SPI, 16'h0000);
    idle(40);

    for (int d = 0; d < 2; d++) begin
      chk("read_queue_left", 16'(rq[d].size()), 16'h0);
      chk("mosi_queue_left", 16'(mq[d].size()), 16'h0);
      chk("partial_byte", 16'(nb[d]), 16'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
